// File: rtl/mdec_out_pack.sv
// mdec_out_pack: MDEC output packer.
// Converts each accepted pixel to 4/8/15/24-bit form and packs the results
// little-endian, nibble by nibble, into 32-bit words for the output FIFO.
// Optional build macro: MDEC_PACK_ROUND_EN selects round-to-nearest (saturating)
// 8-to-5 bit channel reduction for 15-bit pixels; otherwise channels are truncated.
module mdec_out_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  input  logic [1:0]  depth,
  input  logic        sign,
  input  logic        mask,
  input  logic        clr,
  output logic [31:0] out_data,
  output logic        out_we,
  input  logic        out_full,
  output logic        busy
);

  // 12-nibble shift buffer; nibble 0 is the next to leave in out_data[3:0]
  logic [47:0] pack_buf;
  logic [3:0]  cnt;

  logic [7:0]  v_r, v_g, v_b;
  logic [4:0]  r5, g5, b5;
  logic [23:0] pix_bits;
  logic [3:0]  pix_nibbles;
  logic        emit;
  logic        accept;
  logic [3:0]  cnt_after_emit;
  logic [4:0]  fill;
  logic [47:0] buf_after_emit;
  logic [47:0] placed;

`ifdef MDEC_PACK_ROUND_EN
  logic [5:0] r_rnd, g_rnd, b_rnd;

  // (v + 4) >> 3 equals v[7:3] plus a carry from bit 2; bit 5 flags overflow past 5'h1F
  always_comb begin
    r_rnd = {1'b0, v_r[7:3]} + {5'd0, v_r[2]};
    g_rnd = {1'b0, v_g[7:3]} + {5'd0, v_g[2]};
    b_rnd = {1'b0, v_b[7:3]} + {5'd0, v_b[2]};
    r5    = r_rnd[5] ? 5'h1F : r_rnd[4:0];
    g5    = g_rnd[5] ? 5'h1F : g_rnd[4:0];
    b5    = b_rnd[5] ? 5'h1F : b_rnd[4:0];
  end
`else
  // Plain truncation of each channel to its top five bits
  always_comb begin
    r5 = v_r[7:3];
    g5 = v_g[7:3];
    b5 = v_b[7:3];
  end
`endif

  // Sign handling and per-depth formatting of the incoming pixel
  always_comb begin
    v_r         = pix_data[7:0]   ^ (sign ? 8'h00 : 8'h80);
    v_g         = pix_data[15:8]  ^ (sign ? 8'h00 : 8'h80);
    v_b         = pix_data[23:16] ^ (sign ? 8'h00 : 8'h80);
    pix_bits    = 24'd0;
    pix_nibbles = 4'd1;
    case (depth)
      2'd0: begin
        pix_bits    = {20'd0, v_r[7:4]};
        pix_nibbles = 4'd1;
      end
      2'd1: begin
        pix_bits    = {16'd0, v_r};
        pix_nibbles = 4'd2;
      end
      2'd2: begin
        pix_bits    = {v_b, v_g, v_r};
        pix_nibbles = 4'd6;
      end
      default: begin
        pix_bits    = {8'd0, mask, b5, g5, r5};
        pix_nibbles = 4'd4;
      end
    endcase
  end

  // Emit/accept decisions; the new pixel lands above whatever survives this cycle's emit
  always_comb begin
    emit           = ~clr & ~out_full & (cnt >= 4'd8);
    cnt_after_emit = emit ? (cnt - 4'd8) : cnt;
    fill           = {1'b0, cnt_after_emit} + {1'b0, pix_nibbles};
    pix_ready      = ~clr & (fill <= 5'd12);
    accept         = pix_valid & pix_ready;
    buf_after_emit = emit ? {32'd0, pack_buf[47:32]} : pack_buf;
    placed         = {24'd0, pix_bits} << {cnt_after_emit, 2'b00};
  end

  // Buffer and nibble count; clr discards everything including complete words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_buf <= 48'd0;
      cnt      <= 4'd0;
    end else if (clr) begin
      pack_buf <= 48'd0;
      cnt      <= 4'd0;
    end else if (accept) begin
      pack_buf <= buf_after_emit | placed;
      cnt      <= cnt_after_emit + pix_nibbles;
    end else begin
      pack_buf <= buf_after_emit;
      cnt      <= cnt_after_emit;
    end
  end

  // Bits above cnt are always zero, so the low word is stable while a write is stalled
  always_comb begin
    out_data = pack_buf[31:0];
    out_we   = emit;
    busy     = (cnt != 4'd0);
  end

endmodule

// File: tb/tb_mdec_out_pack.sv
// tb_mdec_out_pack: scoreboard bench for mdec_out_pack.
// A nibble queue models the packer: accepted pixels push nibbles, each write pops eight.
module tb_mdec_out_pack;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic [1:0]  depth;
  logic        sign;
  logic        mask;
  logic        clr;
  logic [31:0] out_data;
  logic        out_we;
  logic        out_full;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [3:0]  nq[$];
  logic [31:0] wr_log[$];
  int          wr_cyc[$];

  mdec_out_pack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .depth    (depth),
    .sign     (sign),
    .mask     (mask),
    .clr      (clr),
    .out_data (out_data),
    .out_we   (out_we),
    .out_full (out_full),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int chan(input logic [7:0] b, input logic s);
    return s ? int'(b) : ((int'(b) + 128) % 256);
  endfunction

  function automatic int reduce5(input int v);
    int r;
`ifdef MDEC_PACK_ROUND_EN
    r = (v + 4) / 8;
    if (r > 31) r = 31;
`else
    r = v / 8;
`endif
    return r;
  endfunction

  function automatic int nibCount(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 6;
      default: return 4;
    endcase
  endfunction

  task automatic modelPush(input logic [1:0] d, input logic s, input logic m, input logic [23:0] data);
    int r, g, b, val, n;
    r = chan(data[7:0], s);
    g = chan(data[15:8], s);
    b = chan(data[23:16], s);
    n = nibCount(d);
    case (d)
      2'd0:    val = r / 16;
      2'd1:    val = r;
      2'd2:    val = r + g * 256 + b * 65536;
      default: val = reduce5(r) + reduce5(g) * 32 + reduce5(b) * 1024 + (m ? 32768 : 0);
    endcase
    for (int i = 0; i < n; i++) nq.push_back(4'((val >> (4 * i)) & 15));
  endtask

  // Monitor: compares handshake, status and data against the nibble-queue model each cycle
  logic [31:0] mon_word;
  int          mon_sz;
  logic        mon_we;
  logic        mon_rdy;
  always @(negedge clk) begin
    if (!rst_n) begin
      nq.delete();
    end else begin
      mon_sz  = nq.size();
      mon_we  = (mon_sz >= 8) && !out_full && !clr;
      mon_rdy = !clr && ((mon_sz - (mon_we ? 8 : 0) + nibCount(depth)) <= 12);
      checkOutput("out_we", 32'(out_we), 32'(mon_we));
      checkOutput("pix_ready", 32'(pix_ready), 32'(mon_rdy));
      checkOutput("busy", 32'(busy), 32'(mon_sz != 0));
      if (mon_sz >= 8) begin
        mon_word = 32'd0;
        for (int i = 0; i < 8; i++) mon_word = mon_word | (32'(nq[i]) << (4 * i));
        checkOutput("out_data", out_data, mon_word);
      end
      if (out_we) begin
        wr_log.push_back(out_data);
        wr_cyc.push_back(cycle);
      end
      if (mon_we) begin
        for (int i = 0; i < 8; i++) void'(nq.pop_front());
      end
      if (clr) nq.delete();
      else if (pix_valid && pix_ready) modelPush(depth, sign, mask, pix_data);
    end
  end

  // Presents one pixel and returns just after the edge that accepts it
  task automatic applyStimulus(input logic [1:0] d, input logic s, input logic m, input logic [23:0] data);
    int  tries;
    bit  done;
    depth     = d;
    sign      = s;
    mask      = m;
    pix_data  = data;
    pix_valid = 1'b1;
    tries     = 0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 50) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: pix_ready stayed %b, expected 1", pix_ready);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectWords(input string name, input int n,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] ws[3];
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    checkOutput({name, "_count"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < wr_log.size()) checkOutput(name, wr_log[i], ws[i]);
  endtask

  task automatic clearLog();
    wr_log.delete();
    wr_cyc.delete();
  endtask

  int  acc;
  int  k;
  int  t;
  bit  rdy;

  initial begin
    rst_n     = 1'b1;
    pix_valid = 1'b0;
    pix_data  = 24'd0;
    depth     = 2'd1;
    sign      = 1'b1;
    mask      = 1'b0;
    clr       = 1'b0;
    out_full  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_we", 32'(out_we), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] 8-bit packing");
    clearLog();
    for (int i = 1; i <= 4; i++) applyStimulus(2'd1, 1'b1, 1'b0, 24'(i));
    idleCycles(3);
    expectWords("w8_signed", 1, 32'h04030201, 32'd0, 32'd0);
    clearLog();
    for (int i = 1; i <= 4; i++) applyStimulus(2'd1, 1'b0, 1'b0, 24'(i));
    idleCycles(3);
    expectWords("w8_unsigned", 1, 32'h84838281, 32'd0, 32'd0);

    $display("[TB] 24-bit packing");
    clearLog();
    applyStimulus(2'd2, 1'b1, 1'b0, 24'h302010);
    applyStimulus(2'd2, 1'b1, 1'b0, 24'h605040);
    applyStimulus(2'd2, 1'b1, 1'b0, 24'h908070);
    applyStimulus(2'd2, 1'b1, 1'b0, 24'hC0B0A0);
    idleCycles(4);
    expectWords("w24", 3, 32'h40302010, 32'h80706050, 32'hC0B0A090);
    if (wr_cyc.size() == 3) begin
      checkOutput("w24_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
      checkOutput("w24_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
    end
    checkOutput("w24_busy", 32'(busy), 32'd0);

    $display("[TB] 4-bit packing");
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(2'd0, 1'b1, 1'b0, 24'(i * 16));
    idleCycles(3);
    expectWords("w4", 1, 32'h76543210, 32'd0, 32'd0);

    $display("[TB] 15-bit packing");
    clearLog();
    applyStimulus(2'd3, 1'b1, 1'b1, 24'h0800F8);
    applyStimulus(2'd3, 1'b1, 1'b1, 24'h0800F8);
    applyStimulus(2'd3, 1'b1, 1'b1, 24'h00000C);
    applyStimulus(2'd3, 1'b1, 1'b1, 24'h00000C);
    idleCycles(3);
`ifdef MDEC_PACK_ROUND_EN
    expectWords("w15", 2, 32'h841F841F, 32'h80028002, 32'd0);
`else
    expectWords("w15", 2, 32'h841F841F, 32'h80018001, 32'd0);
`endif

    $display("[TB] backpressure");
    clearLog();
    out_full  = 1'b1;
    depth     = 2'd1;
    sign      = 1'b1;
    k         = 1;
    pix_data  = 24'(k);
    pix_valid = 1'b1;
    acc       = 0;
    repeat (10) begin
      @(negedge clk);
      rdy = pix_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        k++;
        pix_data = 24'(k);
      end
    end
    checkOutput("bp_accepted", 32'(acc), 32'd6);
    checkOutput("bp_ready_low", 32'(pix_ready), 32'd0);
    checkOutput("bp_no_write", 32'(wr_log.size()), 32'd0);
    out_full = 1'b0;
    t = 0;
    while (acc < 8 && t < 20) begin
      @(negedge clk);
      rdy = pix_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        k++;
        pix_data = 24'(k);
      end
      t++;
    end
    checkOutput("bp_resume", 32'(acc), 32'd8);
    idleCycles(4);
    expectWords("bp_words", 2, 32'h04030201, 32'h08070605, 32'd0);

    $display("[TB] flush");
    clearLog();
    for (int i = 1; i <= 3; i++) applyStimulus(2'd1, 1'b1, 1'b0, 24'(i));
    pix_valid = 1'b0;
    clr       = 1'b1;
    @(negedge clk);
    checkOutput("clr_ready", 32'(pix_ready), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    checkOutput("clr_busy", 32'(busy), 32'd0);
    idleCycles(3);
    checkOutput("clr_no_write", 32'(wr_log.size()), 32'd0);

    $display("[TB] asynchronous reset mid-word");
    clearLog();
    for (int i = 0; i < 3; i++) applyStimulus(2'd1, 1'b1, 1'b0, 24'h000055);
    pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_we", 32'(out_we), 32'd0);
    checkOutput("arst_out_data", out_data, 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_pix_ready", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(2);
    checkOutput("arst_no_write", 32'(wr_log.size()), 32'd0);

    $display("[TB] randomized traffic");
    repeat (800) begin
      out_full  = ($urandom % 4) == 0;
      pix_valid = ($urandom % 4) != 0;
      pix_data  = 24'($urandom);
      sign      = 1'($urandom % 2);
      mask      = 1'($urandom % 2);
      if (($urandom % 16) == 0) depth = 2'($urandom % 4);
      clr       = ($urandom % 50) == 0;
      @(posedge clk);
      #1;
    end
    clr      = 1'b0;
    out_full = 1'b0;
    idleCycles(4);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    checkOutput("final_busy", 32'(busy), 32'd0);
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so a stuck run still terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
